// File: rtl/de10_peripheral_responder.sv
// DE10 peripheral-window responder: LED/switch/key registers, 64-bit cycle
// counter and a compare timer, acknowledged through a small request FSM.
module de10_peripheral_responder #(
    parameter int WAIT_STATES = 0,
    parameter int LED_W       = 10,
    parameter int SW_W        = 10,
    parameter int KEY_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             wen,
    input  logic [3:0]       wstrb,
    input  logic [SW_W-1:0]  sw,
    input  logic [KEY_W-1:0] key,
    output logic [31:0]      odata,
    output logic             oready,
    output logic [LED_W-1:0] oled,
    output logic             otimer_irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] OFF_LED   = 3'd0;
    localparam logic [2:0] OFF_SW    = 3'd1;
    localparam logic [2:0] OFF_KEY   = 3'd2;
    localparam logic [2:0] OFF_MLO   = 3'd3;
    localparam logic [2:0] OFF_MHI   = 3'd4;
    localparam logic [2:0] OFF_CMP   = 3'd5;
    localparam logic [2:0] OFF_STAT  = 3'd6;
    localparam logic [2:0] OFF_CTRL  = 3'd7;

    // Replace only the byte lanes enabled by strb.
    function automatic logic [31:0] strobe_merge(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         wcnt_r;
    logic [3:0]         wcnt_s;
    logic               oready_r;
    logic [31:0]        odata_r;
    logic [LED_W-1:0]   led_r;
    logic [SW_W-1:0]    sw_meta_r;
    logic [SW_W-1:0]    sw_sync_r;
    logic [KEY_W-1:0]   key_meta_r;
    logic [KEY_W-1:0]   key_sync_r;
    logic [63:0]        mtime_r;
    logic [31:0]        hi_shadow_r;
    logic [31:0]        cmp_r;
    logic               ctrl_r;
    logic               flag_r;

    logic [2:0]         sel_s;
    logic               commit_s;
    logic               wr_s;
    logic               rd_s;
    logic [31:0]        rdata_s;
    logic [31:0]        led_ext_s;
    logic [31:0]        led_wr_s;
    logic [31:0]        cmp_wr_s;
    logic               flag_set_s;
    logic               flag_clr_s;
    logic               unused_s;

    assign sel_s    = addr[4:2];
    assign commit_s = (state_r == ST_ACK);
    assign wr_s     = commit_s & wen;
    assign rd_s     = commit_s & ~wen;

    // Request FSM next-state logic.
    always_comb begin
        state_s = state_r;
        wcnt_s  = wcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    if (WAIT_STATES == 0) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_WAIT;
                        wcnt_s  = WAIT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Dropping en mid-wait abandons the request without side effects.
                if (!en) begin
                    state_s = ST_IDLE;
                end else if (wcnt_r == 4'd0) begin
                    state_s = ST_ACK;
                end else begin
                    wcnt_s = wcnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                wcnt_s  = 4'd0;
            end
        endcase
    end

    // Request FSM state register and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            wcnt_r   <= 4'd0;
            oready_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            wcnt_r   <= wcnt_s;
            oready_r <= (state_s == ST_ACK);
        end
    end

    // Read mux over the eight word offsets; unlisted bits read zero.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            OFF_LED:  rdata_s[LED_W-1:0] = led_r;
            OFF_SW:   rdata_s[SW_W-1:0]  = sw_sync_r;
            OFF_KEY:  rdata_s[KEY_W-1:0] = key_sync_r;
            OFF_MLO:  rdata_s = mtime_r[31:0];
            OFF_MHI:  rdata_s = hi_shadow_r;
            OFF_CMP:  rdata_s = cmp_r;
            OFF_STAT: rdata_s[0] = flag_r;
            OFF_CTRL: rdata_s[0] = ctrl_r;
            default:  rdata_s = 32'd0;
        endcase
    end

    // Strobe-merged write values for the byte-enabled registers.
    always_comb begin
        led_ext_s             = 32'd0;
        led_ext_s[LED_W-1:0]  = led_r;
        led_wr_s              = strobe_merge(led_ext_s, wdata, wstrb);
        cmp_wr_s              = strobe_merge(cmp_r, wdata, wstrb);
    end

    // A compare match on the same edge as a clear keeps the flag set.
    assign flag_set_s = ctrl_r & (mtime_r[31:0] == cmp_r);
    assign flag_clr_s = wr_s & (sel_s == OFF_STAT) & wstrb[0] & wdata[0];

    // Input synchronisers, free-running counter and timer flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_r  <= '0;
            sw_sync_r  <= '0;
            key_meta_r <= '0;
            key_sync_r <= '0;
            mtime_r    <= 64'd0;
            flag_r     <= 1'b0;
        end else begin
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
            key_meta_r <= key;
            key_sync_r <= key_meta_r;
            mtime_r    <= mtime_r + 64'd1;
            if (flag_set_s) begin
                flag_r <= 1'b1;
            end else if (flag_clr_s) begin
                flag_r <= 1'b0;
            end
        end
    end

    // Bus-visible registers; all updates happen on the ACK edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            odata_r     <= 32'd0;
            led_r       <= '0;
            hi_shadow_r <= 32'd0;
            cmp_r       <= 32'hFFFF_FFFF;
            ctrl_r      <= 1'b0;
        end else begin
            if (rd_s) begin
                odata_r <= rdata_s;
            end
            if (rd_s && (sel_s == OFF_MLO)) begin
                hi_shadow_r <= mtime_r[63:32];
            end
            if (wr_s && (sel_s == OFF_LED)) begin
                led_r <= led_wr_s[LED_W-1:0];
            end
            if (wr_s && (sel_s == OFF_CMP)) begin
                cmp_r <= cmp_wr_s;
            end
            if (wr_s && (sel_s == OFF_CTRL) && wstrb[0]) begin
                ctrl_r <= wdata[0];
            end
        end
    end

    assign unused_s   = ^{addr[31:5], addr[1:0], led_wr_s};

    assign odata      = odata_r;
    assign oready     = oready_r;
    assign oled       = led_r;
    assign otimer_irq = flag_r & ctrl_r;

endmodule

// File: doc/de10_peripheral_responder.md
Name: de10_peripheral_responder

Overview:
Memory-mapped responder for the peripheral window (address tag 10'h1, 0x0040_0000–0x007F_FFFF) of the DE10 bus. It answers requests qualified by the bus controller's peripheral enable and returns a ready pulse and registered read data. Read data is valid the cycle after ready, which matches the controller's delayed-tag read mux. It contains the LED/switch/key registers, a 64-bit cycle counter, and a compare timer with an interrupt output.

Parameters:
WAIT_STATES, 0, extra cycles between request detection and ready (0..15)
LED_W, 10, width of LED output register
SW_W, 10, width of switch input
KEY_W, 4, width of pushbutton input

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  peripheral enable from bus controller; request valid while high
addr  input  32  byte address; only addr[4:2] decoded, upper bits ignored
wdata  input  32  write data
wen  input  1  1 = write, 0 = read; stable while en high
wstrb  input  4  byte enables for writes
sw  input  SW_W  raw switch inputs (asynchronous)
key  input  KEY_W  raw key inputs (asynchronous)
odata  output  32  read data, valid the cycle after ready
oready  output  1  one-cycle acknowledge
oled  output  LED_W  LED register
otimer_irq  output  1  timer interrupt

Behaviour:
- Reset: all registers take their reset values on the first rising clk edge with rst high. State = IDLE, odata = 0, oready = 0, oled = 0, mtime = 0, cmp = 0xFFFF_FFFF, ctrl = 0, flag = 0, hi_shadow = 0, synchroniser flops = 0.
- FSM states: IDLE, WAIT, ACK. oready is 1 only in ACK.
- IDLE: if en = 1 and WAIT_STATES = 0, go to ACK. If en = 1 and WAIT_STATES > 0, load wcnt = WAIT_STATES − 1 and go to WAIT.
- WAIT: if en = 0, abort to IDLE with no side effects. Otherwise, when wcnt = 0 go to ACK, else decrement wcnt.
- ACK: always go to IDLE.
  - On the ACK edge, a write commits, or the read data is registered into odata.
  - odata holds its value until the next read ACK. Writes leave odata unchanged.
- Minimum latency: ready appears WAIT_STATES + 1 cycles after en rises.
- A new request is accepted from IDLE on the cycle after ACK. The back-to-back period is WAIT_STATES + 2 cycles.
- Register map, word offsets on addr[4:2]:
  - 0 LED: rw, low LED_W bits, byte-strobed.
  - 1 SW: ro, two-flop-synchronised sw, zero-extended.
  - 2 KEY: ro, two-flop-synchronised key, zero-extended.
  - 3 MTIME_LO: ro. A read also latches mtime[63:32] into hi_shadow.
  - 4 MTIME_HI: ro, returns hi_shadow.
  - 5 CMP: rw, 32-bit, byte-strobed.
  - 6 STATUS: bit0 = flag. Writing 1 to bit0 (wstrb[0] = 1) clears flag. Other bits read 0.
  - 7 CTRL: bit0 = timer enable, rw. Other bits read 0.
  - Writes to ro registers are ignored. All bits not listed read 0.
- mtime: 64-bit, increments every cycle out of reset, wraps from 2^64−1 to 0. It is not writable.
- Timer: flag sets on any cycle where ctrl[0] = 1 and mtime[31:0] = cmp.
  - If a set and a write-1-to-clear occur on the same edge, set wins.
  - otimer_irq = flag & ctrl[0], combinational from registered state.
- Side effects (hi_shadow latch, writes) happen only on the ACK edge, never in IDLE or WAIT.
- Reset during WAIT or ACK: return to IDLE with no commit and oready = 0 on the next cycle.

Test Plan:
- Reset release, WAIT_STATES = 0. Read LED → oready high exactly 1 cycle after en; odata = 0 one cycle later; oled = 0.
- Write LED, wdata = 0x0000_03A5, wstrb = 4'b0001 → oled = 0x0A5. Then write wstrb = 4'b0010 → oled = 0x3A5. Readback odata = 0x0000_03A5.
- WAIT_STATES = 3: read SW with sw = 10'h2C3 held ≥ 3 cycles → oready 4 cycles after en, odata = 0x0000_02C3. Second run: drop en after 2 cycles → no oready, state back to IDLE.
- Set CMP = 0x40 and CTRL = 1, run mtime past 0x40 → flag and otimer_irq = 1. Write STATUS = 1 on the edge where mtime[31:0] = cmp → flag stays 1. Later clear → otimer_irq = 0.
- Force mtime to 0x0000_0001_FFFF_FFFF via the bench. Read LO, then HI → HI returns 0x0000_0001 even though mtime has since wrapped its low word.
- Assert rst during WAIT of a write to CMP → cmp stays 0xFFFF_FFFF and oready stays 0. Reads of unmapped bits and writes to SW are ignored and return 0.
